// File: rtl/header_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// header_pattern_sequencer
//   Drives bring-up test patterns onto the external breakout header. A run is
//   requested with start and plays one of four patterns (all-toggle,
//   walking-one, walking-zero, checkerboard) for a latched number of passes.
//   Each pattern step is held for DWELL_CYCLES clocks. abort ends a run at
//   once without a done pulse.
//
// Ports
//   clk       PLL global clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     run request, sampled only while idle
//   mode      0 TOGGLE, 1 WALK1, 2 WALK0, 3 CHECKER (latched with start)
//   loops     passes to run, 0 = until abort (latched with start)
//   abort     terminate the current run, highest priority
//   bus_out   header pin drive (registered)
//   busy      run in progress (registered)
//   done      one-cycle pulse on normal completion (registered)
//   step_idx  current step within the pass (registered)
// ---------------------------------------------------------------------------
module header_pattern_sequencer #(
    parameter int unsigned NUM_PINS     = 37,
    parameter int unsigned DWELL_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [7:0]          loops,
    input  logic                abort,
    output logic [NUM_PINS-1:0] bus_out,
    output logic                busy,
    output logic                done,
    output logic [5:0]          step_idx
);

    localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES + 1);
    localparam int unsigned STEP_W  = 6;
    localparam int unsigned PASS_W  = 8;

    localparam logic [1:0] MODE_TOGGLE  = 2'd0;
    localparam logic [1:0] MODE_WALK1   = 2'd1;
    localparam logic [1:0] MODE_WALK0   = 2'd2;
    localparam logic [1:0] MODE_CHECKER = 2'd3;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [STEP_W-1:0]  WALK_LAST  = STEP_W'(NUM_PINS - 1);
    localparam logic [STEP_W-1:0]  PAIR_LAST  = STEP_W'(1);
    localparam logic [PASS_W-1:0]  PASS_MAX   = '1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t              state,     state_nxt;
    logic [NUM_PINS-1:0] bus_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic [STEP_W-1:0]   step_nxt;
    logic [DWELL_W-1:0]  dwell_cnt, dwell_nxt;
    logic [PASS_W-1:0]   pass_cnt,  pass_nxt;
    logic [1:0]          mode_q,    mode_nxt;
    logic [PASS_W-1:0]   loops_q,   loops_nxt;

    logic [STEP_W-1:0]   last_step_c;
    logic [STEP_W-1:0]   step_inc_c;
    logic [PASS_W-1:0]   pass_inc_c;

    // Pin pattern for a given mode and step; bit 0 is pin 0 (even).
    function automatic logic [NUM_PINS-1:0] pattern_f(input logic [1:0]        m,
                                                      input logic [STEP_W-1:0] k);
        logic [NUM_PINS-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < NUM_PINS; i++) begin
            unique case (m)
                MODE_TOGGLE:  p[i] = k[0];
                MODE_WALK1:   p[i] = (STEP_W'(i) == k);
                MODE_WALK0:   p[i] = (STEP_W'(i) != k);
                MODE_CHECKER: p[i] = ((i % 2) == 0) ? ~k[0] : k[0];
                default:      p[i] = 1'b0;
            endcase
        end
        return p;
    endfunction

    // Walking patterns visit every pin; toggle and checker alternate two steps.
    assign last_step_c = (mode_q == MODE_WALK1 || mode_q == MODE_WALK0) ? WALK_LAST : PAIR_LAST;
    assign step_inc_c  = step_idx + STEP_W'(1);
    assign pass_inc_c  = pass_cnt + PASS_W'(1);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bus_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            step_idx  <= '0;
            dwell_cnt <= '0;
            pass_cnt  <= '0;
            mode_q    <= MODE_TOGGLE;
            loops_q   <= '0;
        end else begin
            state     <= state_nxt;
            bus_out   <= bus_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            step_idx  <= step_nxt;
            dwell_cnt <= dwell_nxt;
            pass_cnt  <= pass_nxt;
            mode_q    <= mode_nxt;
            loops_q   <= loops_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        bus_nxt   = bus_out;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        step_nxt  = step_idx;
        dwell_nxt = dwell_cnt;
        pass_nxt  = pass_cnt;
        mode_nxt  = mode_q;
        loops_nxt = loops_q;

        unique case (state)
            ST_IDLE: begin
                bus_nxt   = '0;
                busy_nxt  = 1'b0;
                step_nxt  = '0;
                dwell_nxt = '0;
                pass_nxt  = '0;
                // abort outranks a simultaneous start.
                if (start && !abort) begin
                    state_nxt = ST_RUN;
                    mode_nxt  = mode;
                    loops_nxt = loops;
                    busy_nxt  = 1'b1;
                    bus_nxt   = pattern_f(mode, '0);
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    bus_nxt   = '0;
                    busy_nxt  = 1'b0;
                    step_nxt  = '0;
                    dwell_nxt = '0;
                    pass_nxt  = '0;
                end else if (dwell_cnt == DWELL_LAST) begin
                    dwell_nxt = '0;
                    if (step_idx == last_step_c) begin
                        if (loops_q != '0 && pass_inc_c == loops_q) begin
                            // Final dwell of the final pass.
                            state_nxt = ST_IDLE;
                            bus_nxt   = '0;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                            step_nxt  = '0;
                            pass_nxt  = '0;
                        end else begin
                            step_nxt = '0;
                            bus_nxt  = pattern_f(mode_q, '0);
                            // Endless runs only need the count to stop moving.
                            if (pass_cnt != PASS_MAX) begin
                                pass_nxt = pass_inc_c;
                            end
                        end
                    end else begin
                        step_nxt = step_inc_c;
                        bus_nxt  = pattern_f(mode_q, step_inc_c);
                    end
                end else begin
                    dwell_nxt = dwell_cnt + DWELL_W'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                bus_nxt   = '0;
                busy_nxt  = 1'b0;
                step_nxt  = '0;
                dwell_nxt = '0;
                pass_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_header_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_header_pattern_sequencer
//   Bench for header_pattern_sequencer with NUM_PINS=5, DWELL_CYCLES=3.
//   Expected outputs come from an elapsed-cycle model of a run plus a table
//   of hand-derived run signatures and directed corner-case sequences.
// ---------------------------------------------------------------------------
module tb_header_pattern_sequencer;

    localparam int unsigned NP = 5;
    localparam int unsigned DW = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    mode;
    logic [7:0]    loops;
    logic          abort;
    logic [NP-1:0] bus_out;
    logic          busy;
    logic          done;
    logic [5:0]    step_idx;

    int tests = 0;
    int fails = 0;

    // Reference model: a run is described by its elapsed cycle count.
    bit      m_busy;
    bit      m_done;
    int      m_mode;
    int      m_loops;
    int      m_e;

    header_pattern_sequencer #(
        .NUM_PINS     (NP),
        .DWELL_CYCLES (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .loops    (loops),
        .abort    (abort),
        .bus_out  (bus_out),
        .busy     (busy),
        .done     (done),
        .step_idx (step_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int steps_of(input int md);
        return (md == 1 || md == 2) ? NP : 2;
    endfunction

    function automatic int pat_of(input int md, input int st);
        int all_ones;
        int even;
        all_ones = (1 << NP) - 1;
        even = 0;
        for (int i = 0; i < NP; i += 2) even |= (1 << i);
        case (md)
            0:       return (st == 1) ? all_ones : 0;
            1:       return 1 << st;
            2:       return all_ones & ~(1 << st);
            default: return (st == 0) ? even : (all_ones & ~even);
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_done = 0;
        m_e    = 0;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        m_done = 0;
        if (!m_busy) begin
            if (start && !abort) begin
                m_busy  = 1;
                m_mode  = int'(mode);
                m_loops = int'(loops);
                m_e     = 0;
            end
        end else if (abort) begin
            m_busy = 0;
        end else begin
            m_e++;
            if (m_loops != 0 && m_e == m_loops * steps_of(m_mode) * DW) begin
                m_busy = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic model_check();
        int st;
        st = m_busy ? (m_e / DW) % steps_of(m_mode) : 0;
        chk("model_bus_out",  int'(bus_out),  m_busy ? pat_of(m_mode, st) : 0);
        chk("model_busy",     int'(busy),     int'(m_busy));
        chk("model_done",     int'(done),     int'(m_done));
        chk("model_step_idx", int'(step_idx), st);
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rise.
    task automatic cycle(input logic s, input logic [1:0] md, input logic [7:0] lp, input logic ab);
        @(negedge clk);
        start = s;
        mode  = md;
        loops = lp;
        abort = ab;
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    typedef struct {
        logic [1:0]    mode;
        logic [7:0]    loops;
        logic [NP-1:0] pat0;
        logic [NP-1:0] pat1;
        logic [NP-1:0] pat2;
        int            busy_cycles;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int  off;
        int  busy_cnt;
        bit  seen_done;
        bit  ok;

        vecs[0] = '{2'd1, 8'd1, 5'b00001, 5'b00010, 5'b00100, 15};
        vecs[1] = '{2'd3, 8'd2, 5'b10101, 5'b01010, 5'b10101, 12};
        vecs[2] = '{2'd0, 8'd3, 5'b00000, 5'b11111, 5'b00000, 18};
        vecs[3] = '{2'd2, 8'd1, 5'b11110, 5'b11101, 5'b11011, 15};
        vecs[4] = '{2'd0, 8'd1, 5'b00000, 5'b11111, 5'b00000, 6};

        rst_n = 1'b0;
        start = 1'b0;
        mode  = 2'd0;
        loops = 8'd0;
        abort = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bus_out",  int'(bus_out),  0);
        chk("reset_busy",     int'(busy),     0);
        chk("reset_done",     int'(done),     0);
        chk("reset_step_idx", int'(step_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of run signatures.
        foreach (vecs[v]) begin
            cycle(1'b1, vecs[v].mode, vecs[v].loops, 1'b0);
            off = 0;
            busy_cnt = 0;
            seen_done = 0;
            for (int k = 0; k < 200; k++) begin
                if (off == 0)      chk("vec_pat0", int'(bus_out), int'(vecs[v].pat0));
                if (off == DW)     chk("vec_pat1", int'(bus_out), int'(vecs[v].pat1));
                if (off == 2 * DW) chk("vec_pat2", int'(bus_out), int'(vecs[v].pat2));
                if (busy) busy_cnt++;
                if (done) begin
                    seen_done = 1;
                    break;
                end
                cycle(1'b0, 2'd0, 8'd0, 1'b0);
                off++;
            end
            chk("vec_done_seen", int'(seen_done), 1);
            chk("vec_busy_cycles", busy_cnt, vecs[v].busy_cycles);
        end

        // start and abort together while idle: run must not begin.
        cycle(1'b1, 2'd1, 8'd1, 1'b1);
        chk("start_abort_idle_busy", int'(busy), 0);
        cycle(1'b0, 2'd0, 8'd0, 1'b0);
        chk("start_abort_idle_busy2", int'(busy), 0);

        // start held through completion: ignored at completion, taken after done.
        cycle(1'b1, 2'd3, 8'd1, 1'b0);
        repeat (2 * DW - 1) cycle(1'b1, 2'd0, 8'd1, 1'b0);
        chk("hold_start_still_busy", int'(busy), 1);
        cycle(1'b1, 2'd0, 8'd1, 1'b0);
        chk("hold_start_done", int'(done), 1);
        chk("hold_start_idle", int'(busy), 0);
        cycle(1'b1, 2'd0, 8'd1, 1'b0);
        chk("restart_after_done_busy", int'(busy), 1);
        chk("restart_after_done_bus", int'(bus_out), 0);
        cycle(1'b0, 2'd0, 8'd0, 1'b1);
        chk("restart_abort_busy", int'(busy), 0);

        // start with mode=WALK1 pulsed during a TOGGLE run.
        cycle(1'b1, 2'd0, 8'd2, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cycle(k[0], 2'd1, 8'd5, 1'b0);
            ok = (bus_out == 5'b00000) || (bus_out == 5'b11111);
            chk("toggle_ignores_start", int'(ok), 1);
        end
        seen_done = 0;
        for (int k = 0; k < 50 && !seen_done; k++) begin
            cycle(1'b0, 2'd0, 8'd0, 1'b0);
            if (done) seen_done = 1;
        end
        chk("toggle_run_done", int'(seen_done), 1);

        // Endless WALK0: no done for over 100 cycles, then abort at step 3.
        cycle(1'b1, 2'd2, 8'd0, 1'b0);
        seen_done = 0;
        for (int k = 0; k < 110; k++) begin
            cycle(1'b0, 2'd0, 8'd0, 1'b0);
            if (done || !busy) seen_done = 1;
        end
        chk("walk0_endless_no_done", int'(seen_done), 0);
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (step_idx == 6'd3) ok = 1;
            else cycle(1'b0, 2'd0, 8'd0, 1'b0);
        end
        chk("walk0_reach_step3", int'(ok), 1);
        chk("walk0_step3_bus", int'(bus_out), 5'b10111);
        cycle(1'b0, 2'd0, 8'd0, 1'b1);
        chk("walk0_abort_bus", int'(bus_out), 0);
        chk("walk0_abort_busy", int'(busy), 0);
        chk("walk0_abort_done", int'(done), 0);
        chk("walk0_abort_step", int'(step_idx), 0);
        cycle(1'b0, 2'd0, 8'd0, 1'b0);
        chk("walk0_abort_done_next", int'(done), 0);

        // Asynchronous reset in the middle of WALK1 step 2.
        cycle(1'b1, 2'd1, 8'd1, 1'b0);
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (step_idx == 6'd2) ok = 1;
            else cycle(1'b0, 2'd0, 8'd0, 1'b0);
        end
        chk("rst_mid_reach_step2", int'(ok), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_bus_out", int'(bus_out), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_step", int'(step_idx), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            cycle(1'(($urandom % 6) == 0), 2'($urandom % 4), 8'($urandom % 4),
                  1'(($urandom % 40) == 0));
        end
        cycle(1'b0, 2'd0, 8'd0, 1'b1);
        chk("final_idle", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
